bus_capture_fifo: RTL and testbench

//  Reader end of the shared 8-bit tristate data bus. Samples the bus on a load strobe while

---
 rtl/bus_pkg.sv | 6 +
 rtl/sync_fifo_core.sv | 41 ++++
 rtl/bus_capture_fifo.sv | 49 ++++
 tb/tb_bus_capture_fifo.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for agents on the 8-bit tristate data bus
// (counter, tristate_buffer, bus_capture_fifo).
package bus_pkg;
  localparam int BUS_WIDTH = 8;
  typedef logic [BUS_WIDTH-1:0] bus_word_t;
endpackage

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO storage with wrap-bit pointers; occupancy, full and empty
// are decoded from registered pointers only.
module sync_fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
endmodule

// File: rtl/bus_capture_fifo.sv
// Bus reader: captures bus_in on ld into a FIFO, presents it over valid/ready,
// and flags dropped captures with a sticky overflow bit.
module bus_capture_fifo
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         bus_in,
  input  logic                     ld,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clr_ovf
);
  logic             push, pop, drop, empty;
  logic [WIDTH-1:0] head;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A full queue still accepts a capture when the head leaves in the same cycle.
  assign push      = ld && (!full || pop);
  assign drop      = ld && full && !pop;

  sync_fifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (bus_in),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  assign out_data = empty ? '0 : head;
endmodule

// File: tb/tb_bus_capture_fifo.sv
// Directed self-checking bench for bus_capture_fifo (WIDTH=8, DEPTH=4).
module tb_bus_capture_fifo;
  import bus_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  bus_word_t  bus_in;
  logic       ld, out_ready, clr_ovf;
  bus_word_t  out_data;
  logic       out_valid, full, overflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_capture_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus_in    (bus_in),
    .ld        (ld),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus_in = '0; ld = 0; out_ready = 0; clr_ovf = 0;
    step(); step();
    reset_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
    // asynchronous reset mid-operation
    bus_in = 8'h3C; ld = 1; step(); ld = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_areset_valid got %b exp 1", out_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 8'h00)
      begin errors++; $display("FAIL areset got v=%b c=%0d d=%h exp v=0 c=0 d=00", out_valid, count, out_data); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus_in = 8'hA5; ld = 1; step(); ld = 0; bus_in = 8'h00;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 3'd1)
      begin errors++; $display("FAIL single_push got v=%b d=%h c=%0d exp v=1 d=a5 c=1", out_valid, out_data, count); end
    out_ready = 1; step(); out_ready = 0;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0)
      begin errors++; $display("FAIL single_pop got v=%b c=%0d exp v=0 c=0", out_valid, count); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 5; i++) begin
      bus_in = 8'(i); ld = 1; step();
    end
    ld = 0;
    checks++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b1)
      begin errors++; $display("FAIL fill got c=%0d f=%b o=%b exp c=4 f=1 o=1", count, full, overflow); end
    // drop and clear in the same cycle: drop wins, state unchanged
    bus_in = 8'hEE; ld = 1; clr_ovf = 1; step(); ld = 0; clr_ovf = 0;
    checks++; if (overflow !== 1'b1 || count !== 3'd4)
      begin errors++; $display("FAIL drop_vs_clr got o=%b c=%0d exp o=1 c=4", overflow, count); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_data !== 8'(i) || out_valid !== 1'b1)
        begin errors++; $display("FAIL drain_order got %h v=%b exp %h", out_data, out_valid, 8'(i)); end
      out_ready = 1; step();
    end
    out_ready = 0;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00)
      begin errors++; $display("FAIL drain_empty got v=%b d=%h exp v=0 d=00", out_valid, out_data); end
    checks++; if (overflow !== 1'b1)
      begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    clr_ovf = 1; step(); clr_ovf = 0;
    checks++; if (overflow !== 1'b0)
      begin errors++; $display("FAIL clr_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_simultaneous();
    bus_word_t exp_q[4] = '{8'h22, 8'h33, 8'h44, 8'h77};
    bus_word_t fill_q[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      bus_in = fill_q[i]; ld = 1; step();
    end
    checks++; if (full !== 1'b1)
      begin errors++; $display("FAIL simul_full got %b exp 1", full); end
    bus_in = 8'h77; ld = 1; out_ready = 1; step(); ld = 0; out_ready = 0;
    checks++; if (overflow !== 1'b0 || count !== 3'd4 || full !== 1'b1)
      begin errors++; $display("FAIL simul_pushpop got o=%b c=%0d f=%b exp o=0 c=4 f=1", overflow, count, full); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== exp_q[i])
        begin errors++; $display("FAIL simul_drain got %h exp %h", out_data, exp_q[i]); end
      out_ready = 1; step();
    end
    out_ready = 0;
    checks++; if (count !== 3'd0)
      begin errors++; $display("FAIL simul_empty got c=%0d exp 0", count); end
  endtask

  task automatic test_wrap();
    bus_word_t d;
    for (int i = 0; i < 20; i++) begin
      bus_in = 8'(i * 7 + 3); ld = 1; out_ready = 1;
      if (i > 0) begin
        d = 8'((i - 1) * 7 + 3);
        checks++; if (out_data !== d || out_valid !== 1'b1)
          begin errors++; $display("FAIL wrap_data got %h v=%b exp %h", out_data, out_valid, d); end
      end
      step();
      checks++; if (count > 3'd1)
        begin errors++; $display("FAIL wrap_count got %0d exp <=1", count); end
    end
    ld = 0;
    d = 8'(19 * 7 + 3);
    checks++; if (out_data !== d)
      begin errors++; $display("FAIL wrap_last got %h exp %h", out_data, d); end
    step(); out_ready = 0;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0)
      begin errors++; $display("FAIL wrap_end got v=%b c=%0d exp v=0 c=0", out_valid, count); end
  endtask

  task automatic test_counter();
    bus_word_t cnt = 8'hFE;
    bus_word_t exp_q[3] = '{8'hFE, 8'hFF, 8'h00};
    for (int i = 0; i < 3; i++) begin
      bus_in = cnt; ld = 1; step(); cnt = cnt + 8'd1;
    end
    ld = 0;
    checks++; if (count !== 3'd3)
      begin errors++; $display("FAIL cnt_count got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_data !== exp_q[i] || out_valid !== 1'b1)
        begin errors++; $display("FAIL cnt_drain got %h v=%b exp %h", out_data, out_valid, exp_q[i]); end
      out_ready = 1; step();
    end
    out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_simultaneous();
    test_wrap();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
